// File: rtl/datamem_pkg.sv
// Shared definitions for the sized data memory: access-size encodings,
// controller states and the byte-count helper.
package datamem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bytes touched by an access; 0 for the illegal encoding.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: nbytes = 3'd1;
            SZ_HALF: nbytes = 3'd2;
            SZ_WORD: nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/datamem_lane_align.sv
// Big-endian lane steering: extracts/extends load data from a stored word and
// builds byte enables plus lane-replicated data for stores.
module datamem_lane_align
    import datamem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Load path: lane 0 is the most significant byte of the stored word.
    always_comb begin
        byte_s  = 8'h00;
        half_s  = 16'h0000;
        ld_data = 32'h0000_0000;
        case (lane)
            2'd0:    byte_s = rd_word[31:24];
            2'd1:    byte_s = rd_word[23:16];
            2'd2:    byte_s = rd_word[15:8];
            2'd3:    byte_s = rd_word[7:0];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = rd_word[15:0];
        end else begin
            half_s = rd_word[31:16];
        end
        case (size)
            SZ_BYTE: ld_data = sign_ext ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s};
            SZ_HALF: ld_data = sign_ext ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
            SZ_WORD: ld_data = rd_word;
            default: ld_data = 32'h0000_0000;
        endcase
    end

    // Store path: replicate data across lanes and enable only the addressed bytes.
    always_comb begin
        st_be   = 4'b0000;
        st_word = 32'h0000_0000;
        case (size)
            SZ_BYTE: begin
                st_be   = 4'b1000 >> lane;
                st_word = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                st_be   = lane[1] ? 4'b0011 : 4'b1100;
                st_word = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                st_be   = 4'b1111;
                st_word = wdata;
            end
            default: begin
                st_be   = 4'b0000;
                st_word = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/datamem_sized.sv
// Clocked byte/half/word data memory with valid/ready requests, a registered
// one-cycle response, fault detection and a post-reset init sweep.
module datamem_sized
    import datamem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int OFF_W       = 5,
    parameter int DEPTH_BYTES = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [OFF_W-1:0]  req_off,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
);

    localparam int DEPTH_W = DEPTH_BYTES / 4;
    localparam int IDX_W   = (DEPTH_W > 1) ? $clog2(DEPTH_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_W - 1);
    localparam logic [ADDR_W:0]  LIMIT    = (ADDR_W + 1)'(DEPTH_BYTES);

    generate
        if (DATA_W != 32 || DEPTH_BYTES < 4 || (DEPTH_BYTES % 4) != 0) begin : g_bad_params
            $error("datamem_sized: DATA_W must be 32 and DEPTH_BYTES a multiple of 4, >= 4");
        end
    endgenerate

    logic [31:0]       mem_r [DEPTH_W];
    state_t            state_r;
    state_t            state_s;
    logic [IDX_W-1:0]  cnt_r;
    logic              rsp_valid_r;
    logic [31:0]       rsp_rdata_r;
    logic              rsp_fault_r;

    logic [ADDR_W-1:0] ea_s;
    logic [ADDR_W:0]   end_s;
    logic [IDX_W-1:0]  idx_s;
    logic              fault_s;
    logic              accept_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       ld_data_s;
    logic [3:0]        st_be_s;
    logic [31:0]       st_word_s;
    logic [7:0]        init_b_s;
    logic [31:0]       init_word_s;
    logic [3:0]        we_s;
    logic [IDX_W-1:0]  widx_s;
    logic [31:0]       wword_s;

    assign ea_s      = req_base + ADDR_W'(req_off);
    assign end_s     = {1'b0, ea_s} + (ADDR_W + 1)'(nbytes(req_size));
    assign idx_s     = ea_s[IDX_W+1:2];
    assign rd_word_s = mem_r[idx_s];
    assign req_ready = (state_r == ST_RUN);
    assign accept_s  = req_valid && req_ready;

    // Any illegal size, misalignment or overrun faults the access.
    always_comb begin
        fault_s = 1'b0;
        case (req_size)
            SZ_BYTE: fault_s = 1'b0;
            SZ_HALF: fault_s = ea_s[0];
            SZ_WORD: fault_s = (ea_s[1:0] != 2'b00);
            default: fault_s = 1'b1;
        endcase
        if (end_s > LIMIT) begin
            fault_s = 1'b1;
        end else begin
            fault_s = fault_s;
        end
    end

    datamem_lane_align u_align (
        .size     (req_size),
        .sign_ext (req_signed),
        .lane     (ea_s[1:0]),
        .rd_word  (rd_word_s),
        .wdata    (req_wdata),
        .ld_data  (ld_data_s),
        .st_be    (st_be_s),
        .st_word  (st_word_s)
    );

    // Init pattern: every byte holds its own address mod 256.
    always_comb begin
        init_b_s    = 8'(cnt_r) << 2;
        init_word_s = {init_b_s, init_b_s + 8'd1, init_b_s + 8'd2, init_b_s + 8'd3};
    end

    // Write port arbitration: init sweep, accepted fault-free store, or nothing.
    always_comb begin
        we_s    = 4'b0000;
        widx_s  = cnt_r;
        wword_s = init_word_s;
        if (!rst_n) begin
            we_s = 4'b0000;
        end else if (state_r == ST_INIT) begin
            we_s = 4'b1111;
        end else if (accept_s && req_write && !fault_s) begin
            we_s    = st_be_s;
            widx_s  = idx_s;
            wword_s = st_word_s;
        end else begin
            we_s = 4'b0000;
        end
    end

    // Storage has no reset; the init sweep rewrites it after every reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_s[b]) begin
                mem_r[widx_s][8*b +: 8] <= wword_s[8*b +: 8];
            end
        end
    end

    // Next-state logic: leave INIT after the last word is written.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_INIT: state_s = (cnt_r == LAST_IDX) ? ST_RUN : ST_INIT;
            ST_RUN:  state_s = ST_RUN;
            default: state_s = ST_INIT;
        endcase
    end

    // Controller state, init counter and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            cnt_r       <= '0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_fault_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= (state_r == ST_INIT) ? cnt_r + IDX_W'(1) : cnt_r;
            rsp_valid_r <= accept_s;
            rsp_fault_r <= accept_s && fault_s;
            rsp_rdata_r <= (accept_s && !req_write && !fault_s) ? ld_data_s : 32'h0000_0000;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_fault = rsp_fault_r;

endmodule

// File: tb/tb_datamem_sized.sv
// Directed plus randomized checks of datamem_sized against a byte-array model.
module tb_datamem_sized;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_base;
    logic [4:0]  req_off;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] mem_m [128];

    datamem_sized dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_base   (req_base),
        .req_off    (req_off),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        for (int k = 0; k < 128; k++) mem_m[k] = 8'(k);
    endtask

    // Waits out the init sweep while offering stores that must be ignored.
    task automatic wait_ready();
        for (int i = 0; i < 32; i++) begin
            check($sformatf("ready_low_%0d", i), {31'd0, req_ready}, 32'd0);
            if (i > 0) check($sformatf("no_rsp_init_%0d", i), {31'd0, rsp_valid}, 32'd0);
            req_valid = 1'b1;
            req_write = 1'b1;
            req_size  = 2'($urandom_range(0, 2));
            req_base  = 32'($urandom_range(0, 120)) & 32'hFFFF_FFFC;
            req_off   = 5'd0;
            req_wdata = $urandom;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("ready_high", {31'd0, req_ready}, 32'd1);
    endtask

    // Reset pulse with a store offered on the reset edge; it must not commit.
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_base  = 32'd4;
        req_off   = 5'd0;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        model_init();
        wait_ready();
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] base, input logic [4:0] off, input logic [31:0] wd);
        logic [31:0] ea;
        logic [63:0] last;
        int          nb;
        logic        flt;
        logic [31:0] v;
        ea   = base + {27'd0, off};
        nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
        last = {32'd0, ea} + 64'(nb);
        flt  = (sz == 2'b11) || (sz == 2'b01 && ea % 2 != 0) ||
               (sz == 2'b10 && ea % 4 != 0) || (last > 64'd128);
        v = 32'd0;
        if (!flt && !w) begin
            for (int i = 0; i < nb; i++) v = (v << 8) | {24'd0, mem_m[ea[6:0] + 7'(i)]};
            if (sg && nb == 1) v = {{24{v[7]}}, v[7:0]};
            if (sg && nb == 2) v = {{16{v[15]}}, v[15:0]};
        end
        if (!flt && w) begin
            for (int i = 0; i < nb; i++) mem_m[ea[6:0] + 7'(i)] = 8'(wd >> (8 * (nb - 1 - i)));
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_base = base; req_off = off; req_wdata = wd;
        @(posedge clk); #1;
        check($sformatf("valid ea=%h", ea), {31'd0, rsp_valid}, 32'd1);
        check($sformatf("fault ea=%h sz=%0d", ea, sz), {31'd0, rsp_fault}, {31'd0, flt});
        check($sformatf("rdata ea=%h sz=%0d w=%0b", ea, sz, w), rsp_rdata, v);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_no_rsp", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_base = 32'd0; req_off = 5'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready0", {31'd0, req_ready}, 32'd0);
        check("rst_valid0", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata0", rsp_rdata, 32'd0);
        check("rst_fault0", {31'd0, rsp_fault}, 32'd0);
        rst_n = 1'b1;
        model_init();
        wait_ready();

        do_req(1'b0, 2'b10, 1'b0, 32'd0, 5'd0, 32'd0);
        idle();
        do_req(1'b1, 2'b10, 1'b0, 32'd4, 5'd4, 32'h80FF_1234);
        do_req(1'b0, 2'b00, 1'b1, 32'd8, 5'd0, 32'd0);
        do_req(1'b0, 2'b01, 1'b0, 32'd8, 5'd2, 32'd0);
        do_req(1'b0, 2'b01, 1'b1, 32'd8, 5'd0, 32'd0);
        idle();

        do_reset();
        do_req(1'b0, 2'b10, 1'b0, 32'd6, 5'd0, 32'd0);
        do_req(1'b1, 2'b01, 1'b0, 32'd9, 5'd0, 32'h0000_5555);
        do_req(1'b0, 2'b10, 1'b0, 32'd8, 5'd0, 32'd0);
        do_req(1'b0, 2'b11, 1'b0, 32'd8, 5'd0, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'd124, 5'd0, 32'd0);
        do_req(1'b0, 2'b01, 1'b0, 32'd120, 5'd6, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h7C, 5'd4, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 5'd4, 32'd0);
        do_req(1'b1, 2'b00, 1'b0, 32'd5, 5'd0, 32'h0000_00AB);
        do_req(1'b0, 2'b10, 1'b0, 32'd4, 5'd0, 32'd0);
        do_req(1'b1, 2'b00, 1'b0, 32'd5, 5'd0, 32'h0000_00CD);
        do_reset();
        do_req(1'b0, 2'b10, 1'b0, 32'd4, 5'd0, 32'd0);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] b;
            b = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                            : 32'($urandom_range(0, 140));
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   b, 5'($urandom_range(0, 31)), $urandom);
            if ($urandom_range(0, 5) == 0) idle();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
